dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised RV32IM data memory with a request/response handshake, byte/half/word access by funct3, load sign/zero extension, a programmable wait-state counter and misalignment detection. Sits between the CPU's load/store unit and on-chip block RAM. Replaces the fixed 1 KB word-only data RAM, so the core can execute LB/LH/LBU/LHU/SB/SH and tolerate slower memory.

## Interface
- `DEPTH_WORDS`, 256: memory depth in 32-bit words, power of two, ≥ 4; `AW = clog2(DEPTH_WORDS)`.
- `WAIT_STATES`, 0: extra cycles per access, 0–15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 load/store funct3.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-justified.
- `rsp_valid`  out  1  one-cycle pulse, response present.
- `rsp_rdata`  out  32  load result, extended; 0 for stores and faults.
- `rsp_fault`  out  1  access faulted, no side effect.

## Operation
- Storage is `DEPTH_WORDS` × 32 bits, little-endian byte lanes. It is not cleared by reset and simulation-initialises to 0.
- Word index is `req_addr[AW+1:2]`. Upper address bits are ignored, so addresses beyond the depth wrap.
- A request is accepted when `req_valid && req_ready`. All request fields are latched on acceptance.
- FSM states:
  - IDLE: `req_ready`=1. Goes to WAIT on accept if `WAIT_STATES>0`, otherwise to RESP.
  - WAIT: a counter loads `WAIT_STATES-1` and decrements. Goes to RESP when it reaches 0.
  - RESP: `rsp_valid`=1 for exactly this cycle, then back to IDLE.
- The commit (memory read, write and fault evaluation) happens on the clock edge that enters RESP.
- funct3 decode:
  - 000: byte.
  - 001: half.
  - 010: word.
  - 100: byte, unsigned; loads only.
  - 101: half, unsigned; loads only.
  - Any other code, or 100/101 with `req_we`=1, is illegal: `rsp_fault`=1, no write, `rsp_rdata`=0.
- Stores write only the addressed lanes:
  - SB writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH writes `wdata[15:0]` to lanes `{addr[1],0}` and `{addr[1],1}`.
  - SW writes all four lanes.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW returns the full word.
- Misalignment (half with `addr[0]`=1, word with `addr[1:0]`≠0) is handled per the Configuration section.

## Timing
- Reset values: state IDLE, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, counter 0. `req_ready`=0 while `rst` is high.
- Latency: `rsp_valid` rises `WAIT_STATES+1` cycles after the accept edge.
- Throughput: one access per `WAIT_STATES+2` cycles. No request is accepted during WAIT or RESP.
- `rsp_rdata` and `rsp_fault` are valid only while `rsp_valid`=1 and return to 0 otherwise.
- A load issued after a store to the same word observes the stored data, because accesses are strictly serialised.
- Reset mid-operation: `rst` high in any cycle aborts the access, returns the FSM to IDLE and produces no response. If `rst` is high on the commit edge, the write is suppressed.
- `req_*` inputs are don't-care outside the accept cycle.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses fault: `rsp_fault`=1, no write, `rsp_rdata`=0.
  - Timing is unchanged.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - Misaligned half accesses use `addr[1]` and ignore `addr[0]`.
  - Misaligned word accesses ignore `addr[1:0]`.
  - No fault is raised for misalignment. Illegal funct3 still faults.

## Test plan
- **SW then LW, `WAIT_STATES`=0.** Store `0xCAFEBABE` at `0x20`, then load from `0x20` → `rsp_rdata`=`0xCAFEBABE`. Each `rsp_valid` pulse arrives 1 cycle after its accept.
- **Byte store and signed/unsigned loads.** After the step above, SB `0x80` at `0x21`, then LB `0x21` → `0xFFFFFF80`, LBU `0x21` → `0x00000080`, LW `0x20` → `0xCAFE80BE`.
- **Halfword.** SH `0x1234` at `0x42`, then LH `0x42` → `0x00001234`, LHU `0x40` → `0x00000000`.
- **Wait states, wrap-around and reset.** With `WAIT_STATES`=3 and `DEPTH_WORDS`=256:
  - SW `0x11111111` at `0x400`, LW `0x0` → `0x11111111`, with `rsp_valid` 4 cycles after accept and `req_ready`=0 in between.
  - `rst` on the 2nd wait cycle of an SW → no response, and the location is unchanged.
- **Misalignment with the macro defined.** LW `0x22` → `rsp_fault`=1, `rsp_rdata`=0. SH at `0x41` → fault and memory unchanged.
  - With the macro undefined, LW `0x22` returns the word at `0x20`.
- **Illegal funct3.** funct3=011 load, or SB with funct3=100 → `rsp_fault`=1, no write; the next legal LW returns the old data.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_ctrl_if
//   Request/response bundle between the CPU load/store unit (master) and the
//   data memory controller (slave).
//
//   req_valid  master->slave  request present
//   req_ready  slave->master  controller can accept a request this cycle
//   req_we     master->slave  1 = store, 0 = load
//   req_funct3 master->slave  RV32 load/store funct3
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data, LSB-justified
//   rsp_valid  slave->master  one-cycle response pulse
//   rsp_rdata  slave->master  extended load result (0 for stores/faults)
//   rsp_fault  slave->master  access faulted, no side effect
// ----------------------------------------------------------------------------
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl
//   RV32IM data memory: DEPTH_WORDS x 32-bit little-endian block RAM behind a
//   request/response handshake. Supports LB/LH/LW/LBU/LHU/SB/SH/SW selected by
//   funct3, inserts WAIT_STATES extra cycles per access and flags illegal
//   funct3 codes as faults.
//
//   Parameters
//     DEPTH_WORDS  memory depth in words (power of two, >= 4)
//     WAIT_STATES  extra cycles per access (0..15)
//
//   Ports
//     clk  rising-edge clock
//     rst  synchronous active-high reset (control only; memory is kept)
//     bus  dmem_ctrl_if.slave request/response bundle
//
//   Optional feature
//     DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses
//                            fault instead of being force-aligned.
// ----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Decode / datapath helpers
    // ------------------------------------------------------------------------
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: is_legal = 1'b1;
            3'b100, 3'b101:         is_legal = ~we;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   is_misaligned = a[0];
            2'b10:   is_misaligned = (a != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   store_lanes = 4'b0001 << a;
            2'b01:   store_lanes = a[1] ? 4'b1100 : 4'b0011;
            default: store_lanes = 4'b1111;
        endcase
    endfunction

    // Replicating the narrow store data across the word lets the lane enables
    // alone pick where it lands.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   store_data = {4{wd[7:0]}};
            2'b01:   store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // f3[2] selects the unsigned variants (LBU/LHU).
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   load_extend = {{24{b[7] & ~f3[2]}}, b};
            2'b01:   load_extend = {{16{h[15] & ~f3[2]}}, h};
            default: load_extend = word;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic          we_p0;
    logic [2:0]    f3_p0;
    logic [AW+1:0] addr_p0;
    logic [31:0]   wdata_p0;

    logic [31:0] rdata_p1;
    logic        fault_p1;

    logic          accept;
    logic          commit;
    logic          we_c;
    logic [2:0]    f3_c;
    logic [AW+1:0] addr_c;
    logic [31:0]   wdata_c;
    logic [AW-1:0] word_c;
    logic          fault_c;
    logic [3:0]    lanes_c;
    logic [31:0]   sdata_c;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:AW+2];

    assign accept = bus.req_valid && bus.req_ready;

    // The commit edge is the one entering RESP; rst forces IDLE in the
    // next-state logic, so a reset on that edge also cancels the commit.
    assign commit = (state_nxt == S_RESP);

    // With no wait states the commit coincides with the accept edge, so the
    // live request is used; otherwise the fields latched at accept are used.
    always_comb begin
        if (state == S_IDLE) begin
            we_c    = bus.req_we;
            f3_c    = bus.req_funct3;
            addr_c  = bus.req_addr[AW+1:0];
            wdata_c = bus.req_wdata;
        end else begin
            we_c    = we_p0;
            f3_c    = f3_p0;
            addr_c  = addr_p0;
            wdata_c = wdata_p0;
        end
    end

    assign word_c  = addr_c[AW+1:2];
    assign lanes_c = store_lanes(f3_c, addr_c[1:0]);
    assign sdata_c = store_data(f3_c, wdata_c);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault_c = ~is_legal(we_c, f3_c) | is_misaligned(f3_c, addr_c[1:0]);
`else
    // Misaligned halves/words are force-aligned by the lane decode, so only
    // an illegal funct3 faults.
    logic unused_misalign;
    assign unused_misalign = is_misaligned(f3_c, addr_c[1:0]);
    assign fault_c = ~is_legal(we_c, f3_c);
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (rst) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (WAIT_STATES > 0) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = WAIT_LOAD;
                        end else begin
                            state_nxt = S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state_nxt = S_RESP;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
                S_RESP:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (response data held only for the RESP cycle)
    // ------------------------------------------------------------------------
    always_comb begin
        bus.req_ready = (state == S_IDLE) && !rst;
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_rdata = (state == S_RESP) ? rdata_p1 : 32'd0;
        bus.rsp_fault = (state == S_RESP) ? fault_p1 : 1'b0;
    end

    // ---- p0: request capture at accept ----
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0    <= bus.req_we;
            f3_p0    <= bus.req_funct3;
            addr_p0  <= bus.req_addr[AW+1:0];
            wdata_p0 <= bus.req_wdata;
        end
    end

    // ---- p1: commit (memory access and fault evaluation) ----
    always_ff @(posedge clk) begin
        if (commit && !fault_c && we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes_c[i]) begin
                    mem[word_c][8*i +: 8] <= sdata_c[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            fault_p1 <= fault_c;
            rdata_p1 <= (fault_c || we_c) ? 32'd0
                                          : load_extend(f3_c, addr_c[1:0], mem[word_c]);
        end
    end

endmodule
